mod14_checker: RTL and testbench
================================

MOD14_CHECKER -- requirements
Module: mod14_checker

Interface
REQ-001 SHALL provide parameter MAX_VAL, default 13, meaning the highest legal count value (modulus minus 1).
REQ-002 SHALL provide parameter ERR_W, default 8, meaning the width of the error counter.
REQ-003 SHALL provide port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rest, input, 1, checker reset, asynchronous and active-low.
REQ-005 SHALL provide port chk_en, input, 1, enables checking; low forces the UNSYNC state.
REQ-006 SHALL provide port clr_err, input, 1, synchronous clear of err_sticky and err_cnt.
REQ-007 SHALL provide ports dut_data_in (4), dut_rest (1), dut_mode (1), dut_load (1), all inputs, the observed counter controls (dut_rest: active-high synchronous counter reset; dut_mode: 1 = up, 0 = down).
REQ-008 SHALL provide port dut_data_out, input, 4, the observed counter output.
REQ-009 SHALL provide port synced, output, 1, high while in CHECK.
REQ-010 SHALL provide port exp_out, output, 4, the current model value.
REQ-011 SHALL provide port mismatch, output, 1, a one-cycle pulse per detected miscompare.
REQ-012 SHALL provide port illegal_load, output, 1, a one-cycle pulse when a load with dut_data_in > MAX_VAL is sampled.
REQ-013 SHALL provide ports err_sticky, output, 1, and err_cnt, output, ERR_W, giving the sticky error flag and the saturating error count.

Function
REQ-014 SHALL sample all dut_* inputs on each rising clock edge; edge k is the current edge.
REQ-015 SHALL implement a two-state FSM: UNSYNC, CHECK.
REQ-016 SHALL transition UNSYNC -> CHECK at an edge where chk_en=1 and either dut_rest=1 or (dut_load=1 and dut_data_in <= MAX_VAL).
REQ-017 SHALL transition CHECK -> UNSYNC at an edge where chk_en=0, or where dut_load=1 with dut_data_in > MAX_VAL and dut_rest=0.
REQ-018 SHALL, in CHECK at edge k, compare dut_data_out with model value m; on inequality, pulse mismatch for the cycle following edge k.
REQ-019 SHALL update m at every edge with priority dut_rest -> 0, dut_load -> dut_data_in, dut_mode=1 -> (m==MAX_VAL ? 0 : m+1), dut_mode=0 -> (m==0 ? MAX_VAL : m-1).
REQ-020 SHALL treat dut_rest as overriding a simultaneous illegal load: m becomes 0, no illegal_load pulse, and the state is CHECK.
REQ-021 SHALL perform no compare at an edge where the state is UNSYNC, including the edge of entry into CHECK.
REQ-022 SHALL increment err_cnt once per mismatch, saturating at 2^ERR_W-1, and set err_sticky.
REQ-023 SHALL give clr_err priority over a simultaneous mismatch: after that edge err_cnt=1 and err_sticky=1.
REQ-024 SHALL drive exp_out = m, registered, with no combinational paths from inputs to outputs.

Reset
REQ-025 SHALL, while rest=0, force state UNSYNC, m=0, and synced, mismatch, illegal_load, err_sticky, err_cnt and exp_out all to 0, independent of clock.
REQ-026 SHALL resume operation at the first rising edge after rest deasserts; reset during CHECK discards the model and the error history.

Configuration
REQ-027 SHALL, with MOD14_CHK_WRAP_COV_EN defined, add outputs up_wrap_cnt and dn_wrap_cnt (16 bits each, saturating), counting CHECK-state model transitions 13->0 (up) and 0->13 (down); both are reset to 0.
REQ-028 SHALL, without MOD14_CHK_WRAP_COV_EN, omit these ports and their logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state enum typedef, the MAX_VAL default constant and the next-value function in shared package mod14_pkg.
REQ-030 SHALL implement the model value update (REQ-019) in sub-module mod14_model, with the FSM and error logic in mod14_checker.

Verification
REQ-031 rest=0 mid-CHECK with err_cnt=3 -> all outputs 0 immediately, without a clock edge.
REQ-032 load 12, then up for 3 edges with a correct DUT -> the compared sequence is 12, 13, 0, 1; mismatch never pulses; up_wrap_cnt=1 when enabled.
REQ-033 load 1, then down; DUT reports 2 instead of 0 -> one mismatch pulse, err_cnt=1, err_sticky=1.
REQ-034 load with dut_data_in=14 -> illegal_load pulses, synced=0, no compares until the next legal load or dut_rest.
REQ-035 force 260 consecutive mismatches -> err_cnt saturates at 255; a clr_err coincident with a mismatch -> err_cnt=1.
REQ-036 dut_rest and dut_load with data 15 at the same edge -> m=0, synced=1, no illegal_load pulse.

Source files
------------

// File: rtl/mod14_pkg.sv
// mod14_pkg: shared definitions for the mod-14 counter checker.
//   - chk_state_e   : checker FSM state encoding (UNSYNC / CHECK)
//   - MOD14_MAX_VAL : default highest legal count value
//   - mod14_next()  : reference next-value function of the observed counter
package mod14_pkg;

  localparam int MOD14_MAX_VAL = 13;

  typedef enum logic {
    UNSYNC = 1'b0,
    CHECK  = 1'b1
  } chk_state_e;

  // Reference counter step: reset beats load, load beats counting.
  // Counting wraps inside 0..max_v in either direction.
  function automatic logic [3:0] mod14_next(
    input logic [3:0] m,
    input logic       rst,
    input logic       ld,
    input logic       mode,
    input logic [3:0] din,
    input logic [3:0] max_v
  );
    if (rst)       return 4'd0;
    else if (ld)   return din;
    else if (mode) return (m == max_v) ? 4'd0 : 4'(m + 4'd1);
    else           return (m == 4'd0) ? max_v : 4'(m - 4'd1);
  endfunction

endpackage

// File: rtl/mod14_model.sv
// mod14_model: registered reference model of the observed counter.
// The model follows the DUT controls on every edge, whether or not the
// checker is synchronised, so it is already aligned when CHECK is entered.
// Ports:
//   clock, rest        : clock, async active-low reset
//   dut_rest, dut_load,
//   dut_mode,
//   dut_data_in        : observed counter controls
//   m                  : current model value
module mod14_model
  import mod14_pkg::*;
#(
  parameter int MAX_VAL = MOD14_MAX_VAL
) (
  input  logic       clock,
  input  logic       rest,
  input  logic       dut_rest,
  input  logic       dut_load,
  input  logic       dut_mode,
  input  logic [3:0] dut_data_in,
  output logic [3:0] m
);

  localparam logic [3:0] MAXV = 4'(MAX_VAL);

  always_ff @(posedge clock or negedge rest) begin
    if (!rest) m <= 4'd0;
    else       m <= mod14_next(m, dut_rest, dut_load, dut_mode, dut_data_in, MAXV);
  end

endmodule

// File: rtl/mod14_checker.sv
// mod14_checker: lock-step checker for a modulo-(MAX_VAL+1) up/down counter.
// Synchronises on a counter reset or legal load, then compares the observed
// output against the model every edge while in CHECK.
// Optional: define MOD14_CHK_WRAP_COV_EN to add up/down wrap coverage counters.
// Ports:
//   clock, rest      : clock, async active-low reset
//   chk_en           : checking enable (low drops to UNSYNC)
//   clr_err          : synchronous clear of error flag / count
//   dut_*            : observed counter controls and output
//   synced           : high while in CHECK
//   exp_out          : model value
//   mismatch         : one-cycle pulse per miscompare
//   illegal_load     : one-cycle pulse per out-of-range load
//   err_sticky       : sticky error flag
//   err_cnt          : saturating error count
//   up_wrap_cnt,
//   dn_wrap_cnt      : (optional) saturating wrap counts in CHECK
module mod14_checker
  import mod14_pkg::*;
#(
  parameter int MAX_VAL = MOD14_MAX_VAL,
  parameter int ERR_W   = 8
) (
  input  logic             clock,
  input  logic             rest,
  input  logic             chk_en,
  input  logic             clr_err,
  input  logic [3:0]       dut_data_in,
  input  logic             dut_rest,
  input  logic             dut_mode,
  input  logic             dut_load,
  input  logic [3:0]       dut_data_out,
  output logic             synced,
  output logic [3:0]       exp_out,
  output logic             mismatch,
  output logic             illegal_load,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
`ifdef MOD14_CHK_WRAP_COV_EN
  ,
  output logic [15:0]      up_wrap_cnt,
  output logic [15:0]      dn_wrap_cnt
`endif
);

  localparam logic [3:0]       MAXV    = 4'(MAX_VAL);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_e state, state_nxt;
  logic [3:0] m;
  logic       cmp_en, miss, ill_ld;

  mod14_model #(.MAX_VAL(MAX_VAL)) u_model (
    .clock       (clock),
    .rest        (rest),
    .dut_rest    (dut_rest),
    .dut_load    (dut_load),
    .dut_mode    (dut_mode),
    .dut_data_in (dut_data_in),
    .m           (m)
  );

  // No compare on the entry edge: the state is still UNSYNC there.
  assign cmp_en = (state == CHECK) && chk_en;
  assign miss   = cmp_en && (dut_data_out != m);
  // A counter reset on the same edge overrides an out-of-range load.
  assign ill_ld = dut_load && !dut_rest && (dut_data_in > MAXV);

  always_comb begin
    state_nxt = state;
    if (!chk_en)                                 state_nxt = UNSYNC;
    else if (dut_rest)                           state_nxt = CHECK;
    else if (dut_load && (dut_data_in <= MAXV))  state_nxt = CHECK;
    else if (dut_load)                           state_nxt = UNSYNC;
  end

  always_ff @(posedge clock or negedge rest) begin
    if (!rest) begin
      state        <= UNSYNC;
      mismatch     <= 1'b0;
      illegal_load <= 1'b0;
      err_sticky   <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      mismatch     <= miss;
      illegal_load <= ill_ld;
      // Clear wins, but a miscompare on the clearing edge is still recorded.
      if (clr_err) begin
        err_sticky <= miss;
        err_cnt    <= miss ? ERR_W'(1) : '0;
      end else if (miss) begin
        err_sticky <= 1'b1;
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

  assign synced  = (state == CHECK);
  assign exp_out = m;

`ifdef MOD14_CHK_WRAP_COV_EN
  logic cnt_step;
  assign cnt_step = (state == CHECK) && !dut_rest && !dut_load;

  always_ff @(posedge clock or negedge rest) begin
    if (!rest) begin
      up_wrap_cnt <= '0;
      dn_wrap_cnt <= '0;
    end else begin
      if (cnt_step && dut_mode && (m == MAXV) && (up_wrap_cnt != 16'hFFFF))
        up_wrap_cnt <= up_wrap_cnt + 16'd1;
      if (cnt_step && !dut_mode && (m == 4'd0) && (dn_wrap_cnt != 16'hFFFF))
        dn_wrap_cnt <= dn_wrap_cnt + 16'd1;
    end
  end
`else
  // Wrap coverage not built.
`endif

endmodule

// File: tb/tb_mod14_checker.sv
// tb_mod14_checker: directed self-checking bench for mod14_checker.
// Inputs are changed 1 time unit after the rising edge; outputs are checked
// at that same point, i.e. well away from the active edge.
module tb_mod14_checker;

  logic       clock = 1'b0;
  logic       rest;
  logic       chk_en, clr_err;
  logic [3:0] dut_data_in, dut_data_out;
  logic       dut_rest, dut_mode, dut_load;
  logic       synced, mismatch, illegal_load, err_sticky;
  logic [3:0] exp_out;
  logic [7:0] err_cnt;
`ifdef MOD14_CHK_WRAP_COV_EN
  logic [15:0] up_wrap_cnt, dn_wrap_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mod14_checker #(.MAX_VAL(13), .ERR_W(8)) dut (
    .clock        (clock),
    .rest         (rest),
    .chk_en       (chk_en),
    .clr_err      (clr_err),
    .dut_data_in  (dut_data_in),
    .dut_rest     (dut_rest),
    .dut_mode     (dut_mode),
    .dut_load     (dut_load),
    .dut_data_out (dut_data_out),
    .synced       (synced),
    .exp_out      (exp_out),
    .mismatch     (mismatch),
    .illegal_load (illegal_load),
    .err_sticky   (err_sticky),
    .err_cnt      (err_cnt)
`ifdef MOD14_CHK_WRAP_COV_EN
    ,
    .up_wrap_cnt  (up_wrap_cnt),
    .dn_wrap_cnt  (dn_wrap_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic drv(input logic r, input logic ld, input logic md,
                     input logic [3:0] din, input logic [3:0] dout);
    dut_rest = r; dut_load = ld; dut_mode = md;
    dut_data_in = din; dut_data_out = dout;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rest = 1'b0; chk_en = 1'b0; clr_err = 1'b0;
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    #3;
    // reset state
    chk("rst_synced",   synced,       0);
    chk("rst_exp",      exp_out,      0);
    chk("rst_mismatch", mismatch,     0);
    chk("rst_illegal",  illegal_load, 0);
    chk("rst_sticky",   err_sticky,   0);
    chk("rst_errcnt",   err_cnt,      0);
    #10 rest = 1'b1;
    step();

    // load 12, then count up across the wrap with a correct DUT
    chk_en = 1'b1;
    drv(1'b0, 1'b1, 1'b1, 4'd12, 4'd0);
    step();
    chk("ld12_synced", synced,  1);
    chk("ld12_exp",    exp_out, 12);
    chk("ld12_mis",    mismatch, 0);
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd12); step();
    chk("up_exp13", exp_out, 13); chk("up_mis_a", mismatch, 0);
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd13); step();
    chk("up_exp0",  exp_out, 0);  chk("up_mis_b", mismatch, 0);
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);  step();
    chk("up_exp1",  exp_out, 1);  chk("up_mis_c", mismatch, 0);
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd1);  step();
    chk("up_exp2",  exp_out, 2);  chk("up_mis_d", mismatch, 0);
    chk("up_errcnt", err_cnt, 0);
`ifdef MOD14_CHK_WRAP_COV_EN
    chk("up_wrap", up_wrap_cnt, 1);
`endif

    // load 1, count down; DUT shows 2 where 0 is expected
    drv(1'b0, 1'b1, 1'b0, 4'd1, 4'd2); step();
    chk("ld1_exp", exp_out, 1); chk("ld1_mis", mismatch, 0);
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd1); step();
    chk("dn_exp0", exp_out, 0); chk("dn_mis_a", mismatch, 0);
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd2); step();
    chk("dn_exp13", exp_out, 13);
    chk("dn_mis_pulse", mismatch, 1);
    chk("dn_errcnt", err_cnt, 1);
    chk("dn_sticky", err_sticky, 1);
    drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd13); step();
    chk("dn_mis_end", mismatch, 0);
    chk("dn_errcnt_hold", err_cnt, 1);
`ifdef MOD14_CHK_WRAP_COV_EN
    chk("dn_wrap", dn_wrap_cnt, 1);
`endif

    // illegal load of 14 drops sync; later wrong data is not compared
    drv(1'b0, 1'b1, 1'b1, 4'd14, 4'd12); step();
    chk("ill_pulse",  illegal_load, 1);
    chk("ill_synced", synced, 0);
    chk("ill_exp",    exp_out, 14);
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd7); step();
    chk("ill_pulse_end", illegal_load, 0);
    chk("ill_nocmp_a", mismatch, 0);
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd7); step();
    chk("ill_nocmp_b", mismatch, 0);
    chk("ill_errcnt", err_cnt, 1);

    // counter reset with simultaneous load of 15: reset wins
    drv(1'b1, 1'b1, 1'b1, 4'd15, 4'd9); step();
    chk("rl_exp",     exp_out, 0);
    chk("rl_synced",  synced, 1);
    chk("rl_illegal", illegal_load, 0);
    chk("rl_mis",     mismatch, 0);

    // 260 consecutive miscompares (model never reaches 15)
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd15);
    for (int i = 0; i < 260; i++) step();
    chk("sat_errcnt", err_cnt, 255);
    chk("sat_mis", mismatch, 1);
    chk("sat_exp", exp_out, 8);   // 260 mod 14
    clr_err = 1'b1; step();
    chk("clr_mis_errcnt", err_cnt, 1);
    chk("clr_mis_sticky", err_sticky, 1);
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd9); step();
    chk("clr_errcnt", err_cnt, 0);
    chk("clr_sticky", err_sticky, 0);
    clr_err = 1'b0;

    // chk_en low drops sync
    chk_en = 1'b0; drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd15); step();
    chk("en_off_synced", synced, 0);
    step();
    chk("en_off_nocmp", err_cnt, 0);

    // build err_cnt=3 in CHECK, then async reset without a clock edge
    chk_en = 1'b1; drv(1'b1, 1'b0, 1'b1, 4'd0, 4'd0); step();
    drv(1'b0, 1'b0, 1'b1, 4'd0, 4'd15);
    step(); step(); step();
    chk("pre_ar_errcnt", err_cnt, 3);
    chk("pre_ar_synced", synced, 1);
    #2 rest = 1'b0;
    #1;
    chk("ar_synced",   synced, 0);
    chk("ar_exp",      exp_out, 0);
    chk("ar_mis",      mismatch, 0);
    chk("ar_errcnt",   err_cnt, 0);
    chk("ar_sticky",   err_sticky, 0);
    chk("ar_illegal",  illegal_load, 0);
    #4 rest = 1'b1;
    step();
    chk("post_ar_synced", synced, 0);
    chk("post_ar_errcnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
